mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Arbiter that shares one single-port, word-addressed synchronous memory between the pipeline's instruction-fetch port (IF stage) and its data port (MEM stage). It replaces the separate instruction and data memories with one unified memory. Each cycle it grants at most one requester, returns read data one cycle later with a valid pulse, and raises per-stage stall outputs that the hazard logic ORs into PC/IFID write enables and pipeline holds. A starvation counter keeps IF fetches progressing during long runs of loads and stores.

## Interface
- AW, 10: word-address width (4 KB memory)
- DW, 32: data width
- STARVE_MAX, 4: consecutive denied IF cycles before IF gets forced priority (1..15)
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, synchronous active-high
- if_req  in  1  fetch request
- if_addr  in  AW  fetch word address (pc[11:2])
- if_gnt  out  1  fetch accepted this cycle (combinational)
- if_rdata  out  DW  fetched instruction, registered, held until the next IF response
- if_rvalid  out  1  one-cycle pulse, the cycle after an IF grant
- dm_req  in  1  data request
- dm_we  in  1  data request is a write
- dm_addr  in  AW  data word address
- dm_wdata  in  DW  store data
- dm_gnt  out  1  data request accepted this cycle (combinational)
- dm_rdata  out  DW  load data, registered, held until the next DM read response
- dm_rvalid  out  1  one-cycle pulse, the cycle after a DM read grant (never for writes)
- stall_if  out  1  = if_req & ~if_gnt
- stall_mm  out  1  = dm_req & ~dm_gnt
- mem_en  out  1  memory access enable
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_din  out  DW  memory write data
- mem_dout  in  DW  memory read data, valid one cycle after mem_en & ~mem_we
- perf_conflicts  out  16  count of cycles in which both requesters asserted, saturating

## Operation
- Grant rules, evaluated combinationally each cycle:
  - Only one requester active: that requester is granted.
  - Both active: DM is granted, unless starve_cnt == STARVE_MAX, in which case IF is granted.
- Memory drive: the granted port's address/data drive mem_*. mem_en = if_gnt | dm_gnt. mem_we = dm_gnt & dm_we. No grant: mem_en = 0, and address/data hold their last values.
- Response owner register resp_own ∈ {NONE, IF, DM}. It is loaded each cycle with IF on an IF grant, DM on a DM read grant, and NONE otherwise (including DM write grants).
- Cycle after the grant:
  - resp_own == IF: if_rdata <= mem_dout and if_rvalid = 1.
  - resp_own == DM: dm_rdata <= mem_dout and dm_rvalid = 1.
- starve_cnt (4 bit):
  - Cleared when if_req = 0 or if_gnt = 1.
  - Otherwise incremented when IF is denied.
  - Never exceeds STARVE_MAX.
- perf_conflicts increments on every cycle with if_req & dm_req, and saturates at 16'hFFFF.
- Same-address conflict (DM write vs IF read in the same cycle): the write wins. IF retries next cycle and must read the new data.
- mem_dout during a write cycle is ignored. A write never produces a response.

## Timing
- Grant latency 0 (same cycle as req). Read latency 1 cycle (rvalid the cycle after the grant).
- Back-to-back grants to any mix of ports are legal every cycle. Throughput is one access per cycle.
- Requesters hold req/addr/data stable until they see gnt. A dropped request is simply not served.
- Reset values: if_rdata, dm_rdata, perf_conflicts = 0; if_rvalid, dm_rvalid = 0; starve_cnt = 0; resp_own = NONE; mem_addr, mem_din = 0.
- Combinational outputs (gnt, stall, mem_en, mem_we) are also forced to 0 while rst = 1.
- Reset mid-operation: a response pending from the pre-reset cycle is dropped. No rvalid is produced in the cycle after reset deasserts.

## Structure
- Shared package/declarations header holds:
  - the resp_own encoding: `OWN_NONE` = 2'd0, `OWN_IF` = 2'd1, `OWN_DM` = 2'd2;
  - the STARVE_MAX default.
- One sub-module: `starve_counter` (saturating up-counter with clear, limit input, and at-limit flag).
- Grant logic, response register and perf counter stay in mem_arbiter.

## Test plan
- IF only, if_req = 1 over addresses 0..3 → if_gnt = 1 every cycle; if_rvalid every cycle from cycle 1, with data = mem[0..3] in order; stall_if = 0.
- Both requesting continuously, STARVE_MAX = 4 → DM granted in cycles 0–3, IF in cycle 4, then the pattern repeats; stall_if is high in 4 of every 5 cycles.
- Same cycle: DM write 32'hDEADBEEF to address 5 and IF read of address 5 → DM granted, stall_if = 1; IF granted next cycle and returns 32'hDEADBEEF; no dm_rvalid.
- DM read of address 7 (holding 32'h1234_5678) alone → dm_gnt in cycle 0, dm_rvalid = 1 with dm_rdata = 32'h12345678 in cycle 1; dm_rdata is held after the pulse.
- rst asserted in the cycle after an IF grant → no if_rvalid; all outputs 0; perf_conflicts = 0; the first request after reset behaves as in the first scenario.
- 70000 conflict cycles → perf_conflicts saturates at 16'hFFFF.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared declarations for the unified instruction/data memory arbiter:
// response-owner encoding and the default starvation limit.
package mem_arbiter_pkg;

    // Response owner: which port receives mem_dout in the following cycle
    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_IF   = 2'd1;
    localparam logic [1:0] OWN_DM   = 2'd2;

    // Consecutive denied IF cycles before IF is forced ahead of DM
    localparam int STARVE_MAX_DEF = 4;

    // Width of the conflict performance counter
    localparam int PERF_W = 16;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of requester handshakes and memory-side signals for mem_arbiter.
// slave  : the arbiter's view (requests in, grants/responses/memory drive out)
// master : the pipeline + memory view (opposite directions)
interface mem_arbiter_if #(
    parameter int AW = 10,
    parameter int DW = 32
);
    import mem_arbiter_pkg::*;

    // Instruction-fetch port
    logic              if_req;
    logic [AW-1:0]     if_addr;
    logic              if_gnt;
    logic [DW-1:0]     if_rdata;
    logic              if_rvalid;

    // Data port
    logic              dm_req;
    logic              dm_we;
    logic [AW-1:0]     dm_addr;
    logic [DW-1:0]     dm_wdata;
    logic              dm_gnt;
    logic [DW-1:0]     dm_rdata;
    logic              dm_rvalid;

    // Hazard-logic stalls
    logic              stall_if;
    logic              stall_mm;

    // Single-port memory
    logic              mem_en;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_din;
    logic [DW-1:0]     mem_dout;

    // Performance counter
    logic [PERF_W-1:0] perf_conflicts;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rdata, if_rvalid,
        input  dm_req, dm_we, dm_addr, dm_wdata,
        output dm_gnt, dm_rdata, dm_rvalid,
        output stall_if, stall_mm,
        output mem_en, mem_we, mem_addr, mem_din,
        input  mem_dout,
        output perf_conflicts
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rdata, if_rvalid,
        output dm_req, dm_we, dm_addr, dm_wdata,
        input  dm_gnt, dm_rdata, dm_rvalid,
        input  stall_if, stall_mm,
        input  mem_en, mem_we, mem_addr, mem_din,
        output mem_dout,
        input  perf_conflicts
    );

endinterface

// File: rtl/mem_arbiter_starve_counter.sv
// Saturating up-counter with clear. Counts consecutive cycles in which the
// fetch port was denied and flags when the count has reached the limit.
module starve_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr_i,
    input  logic       inc_i,
    input  logic [3:0] limit_i,
    output logic       at_lim_o
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    // Next count: clear wins, otherwise increment until the limit is reached
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 4'd0;
        end else if (inc_i && (cnt_q < limit_i)) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    // Counter register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_lim_o = (cnt_q == limit_i);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous memory between the IF and MEM stages.
// DM normally has priority; IF is forced through after STARVE_MAX denials.
// Read data returns one cycle after the grant with a one-cycle valid pulse.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW         = 10,
    parameter int DW         = 32,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic            clk,
    input  logic            rst,
    mem_arbiter_if.slave    bus
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic              if_gnt;
    logic              dm_gnt;
    logic              at_lim;
    logic              conflict;

    logic [AW-1:0]     addr_q,  addr_d;
    logic [DW-1:0]     din_q,   din_d;
    logic [1:0]        own_q,   own_d;
    logic [DW-1:0]     if_rdata_q;
    logic [DW-1:0]     dm_rdata_q;
    logic [PERF_W-1:0] perf_q;

    // Saturating increment for the performance counter
    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        return (v == {PERF_W{1'b1}}) ? v : v + PERF_W'(1);
    endfunction

    assign conflict = bus.if_req & bus.dm_req;

    // Grant: DM wins a conflict unless IF has been starved up to the limit
    always_comb begin
        if_gnt = 1'b0;
        dm_gnt = 1'b0;
        if (!rst) begin
            if (bus.if_req && (!bus.dm_req || at_lim)) begin
                if_gnt = 1'b1;
            end else if (bus.dm_req) begin
                dm_gnt = 1'b1;
            end
        end
    end

    starve_counter u_starve (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (~bus.if_req | if_gnt),
        .inc_i    (bus.if_req & ~if_gnt),
        .limit_i  (STARVE_LIM),
        .at_lim_o (at_lim)
    );

    // Memory drive: granted port's address/data, otherwise hold last values
    always_comb begin
        addr_d = addr_q;
        din_d  = din_q;
        if (if_gnt) begin
            addr_d = bus.if_addr;
        end else if (dm_gnt) begin
            addr_d = bus.dm_addr;
            din_d  = bus.dm_wdata;
        end
    end

    // Response owner for the following cycle; writes never respond
    always_comb begin
        own_d = OWN_NONE;
        if (if_gnt) begin
            own_d = OWN_IF;
        end else if (dm_gnt && !bus.dm_we) begin
            own_d = OWN_DM;
        end
    end

    // Held memory address/data and response owner
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            din_q  <= '0;
            own_q  <= OWN_NONE;
        end else begin
            addr_q <= addr_d;
            din_q  <= din_d;
            own_q  <= own_d;
        end
    end

    // Capture returned read data so it stays visible after the valid pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            if (own_q == OWN_IF) begin
                if_rdata_q <= bus.mem_dout;
            end
            if (own_q == OWN_DM) begin
                dm_rdata_q <= bus.mem_dout;
            end
        end
    end

    // Count cycles with both ports requesting, saturating at all ones
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_q <= '0;
        end else if (conflict) begin
            perf_q <= sat_inc(perf_q);
        end
    end

    // Outputs; everything reads as zero while reset is held, which also
    // drops a response pending from the cycle before reset
    assign bus.if_gnt    = if_gnt;
    assign bus.dm_gnt    = dm_gnt;
    assign bus.stall_if  = ~rst & bus.if_req & ~if_gnt;
    assign bus.stall_mm  = ~rst & bus.dm_req & ~dm_gnt;

    assign bus.mem_en    = if_gnt | dm_gnt;
    assign bus.mem_we    = dm_gnt & bus.dm_we;
    assign bus.mem_addr  = rst ? '0 : addr_d;
    assign bus.mem_din   = rst ? '0 : din_d;

    assign bus.if_rvalid = ~rst & (own_q == OWN_IF);
    assign bus.dm_rvalid = ~rst & (own_q == OWN_DM);
    assign bus.if_rdata  = rst ? '0 : ((own_q == OWN_IF) ? bus.mem_dout : if_rdata_q);
    assign bus.dm_rdata  = rst ? '0 : ((own_q == OWN_DM) ? bus.mem_dout : dm_rdata_q);

    assign bus.perf_conflicts = rst ? '0 : perf_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural single-port memory.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst;
    logic preload;
    int   total = 0;
    int   passed = 0;

    logic [31:0] mem [0:1023];

    mem_arbiter_if #(.AW(10), .DW(32)) bus ();

    mem_arbiter #(.AW(10), .DW(32), .STARVE_MAX(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Synchronous single-port memory, registered read data
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'hA000_0000 + 32'(i);
            mem[7] <= 32'h1234_5678;
        end else if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_din;
            else            bus.mem_dout <= mem[bus.mem_addr];
        end
    end

    task automatic idle_inputs();
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        bus.if_req = 1'b1; bus.dm_req = 1'b1; bus.dm_addr = 10'd3;
        @(negedge clk);
        total++; if (bus.if_gnt !== 1'b0) $display("FAIL rst_if_gnt got %b want 0", bus.if_gnt); else passed++;
        total++; if (bus.dm_gnt !== 1'b0) $display("FAIL rst_dm_gnt got %b want 0", bus.dm_gnt); else passed++;
        total++; if (bus.mem_en !== 1'b0) $display("FAIL rst_mem_en got %b want 0", bus.mem_en); else passed++;
        total++; if (bus.stall_if !== 1'b0) $display("FAIL rst_stall_if got %b want 0", bus.stall_if); else passed++;
        total++; if (bus.stall_mm !== 1'b0) $display("FAIL rst_stall_mm got %b want 0", bus.stall_mm); else passed++;
        total++; if (bus.if_rvalid !== 1'b0) $display("FAIL rst_if_rvalid got %b want 0", bus.if_rvalid); else passed++;
        total++; if (bus.dm_rvalid !== 1'b0) $display("FAIL rst_dm_rvalid got %b want 0", bus.dm_rvalid); else passed++;
        total++; if (bus.perf_conflicts !== 16'd0) $display("FAIL rst_perf got %0d want 0", bus.perf_conflicts); else passed++;
        total++; if (bus.mem_addr !== 10'd0) $display("FAIL rst_mem_addr got %0d want 0", bus.mem_addr); else passed++;
        total++; if (bus.if_rdata !== 32'd0) $display("FAIL rst_if_rdata got %h want 0", bus.if_rdata); else passed++;
        idle_inputs();
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_if_only(input string tag);
        for (int k = 0; k < 5; k++) begin
            bus.if_req = (k < 4); bus.if_addr = 10'(k);
            @(negedge clk);
            if (k < 4) begin
                total++; if (bus.if_gnt !== 1'b1) $display("FAIL %s_gnt c%0d got %b want 1", tag, k, bus.if_gnt); else passed++;
                total++; if (bus.stall_if !== 1'b0) $display("FAIL %s_stall c%0d got %b want 0", tag, k, bus.stall_if); else passed++;
                total++; if (bus.mem_addr !== 10'(k)) $display("FAIL %s_addr c%0d got %0d want %0d", tag, k, bus.mem_addr, k); else passed++;
            end
            if (k == 0) begin
                total++; if (bus.if_rvalid !== 1'b0) $display("FAIL %s_rvalid c0 got %b want 0", tag, bus.if_rvalid); else passed++;
            end else begin
                total++; if (bus.if_rvalid !== 1'b1) $display("FAIL %s_rvalid c%0d got %b want 1", tag, k, bus.if_rvalid); else passed++;
                total++; if (bus.if_rdata !== 32'hA000_0000 + 32'(k - 1))
                    $display("FAIL %s_rdata c%0d got %h want %h", tag, k, bus.if_rdata, 32'hA000_0000 + 32'(k - 1)); else passed++;
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_starvation();
        int stalls = 0;
        logic exp_if;
        bus.if_req = 1'b1; bus.if_addr = 10'd2;
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 10'd1;
        for (int c = 0; c < 10; c++) begin
            exp_if = ((c % 5) == 4);
            @(negedge clk);
            if (bus.stall_if) stalls++;
            total++; if (bus.if_gnt !== exp_if) $display("FAIL starve_if_gnt c%0d got %b want %b", c, bus.if_gnt, exp_if); else passed++;
            total++; if (bus.dm_gnt !== !exp_if) $display("FAIL starve_dm_gnt c%0d got %b want %b", c, bus.dm_gnt, !exp_if); else passed++;
            total++; if (bus.stall_mm !== exp_if) $display("FAIL starve_stall_mm c%0d got %b want %b", c, bus.stall_mm, exp_if); else passed++;
            next_cycle();
        end
        idle_inputs();
        @(negedge clk);
        total++; if (stalls != 8) $display("FAIL starve_stall_count got %0d want 8", stalls); else passed++;
        total++; if (bus.if_rvalid !== 1'b1) $display("FAIL starve_if_rvalid got %b want 1", bus.if_rvalid); else passed++;
        total++; if (bus.if_rdata !== 32'hA000_0002) $display("FAIL starve_if_rdata got %h want a0000002", bus.if_rdata); else passed++;
        total++; if (bus.perf_conflicts !== 16'd10) $display("FAIL starve_perf got %0d want 10", bus.perf_conflicts); else passed++;
        next_cycle();
    endtask

    task automatic test_same_addr();
        bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 10'd5; bus.dm_wdata = 32'hDEAD_BEEF;
        bus.if_req = 1'b1; bus.if_addr = 10'd5;
        @(negedge clk);
        total++; if (bus.dm_gnt !== 1'b1) $display("FAIL same_dm_gnt got %b want 1", bus.dm_gnt); else passed++;
        total++; if (bus.stall_if !== 1'b1) $display("FAIL same_stall_if got %b want 1", bus.stall_if); else passed++;
        total++; if (bus.mem_we !== 1'b1) $display("FAIL same_mem_we got %b want 1", bus.mem_we); else passed++;
        next_cycle();
        bus.dm_req = 1'b0; bus.dm_we = 1'b0;
        @(negedge clk);
        total++; if (bus.if_gnt !== 1'b1) $display("FAIL same_if_gnt got %b want 1", bus.if_gnt); else passed++;
        total++; if (bus.dm_rvalid !== 1'b0) $display("FAIL same_dm_rvalid1 got %b want 0", bus.dm_rvalid); else passed++;
        next_cycle();
        bus.if_req = 1'b0;
        @(negedge clk);
        total++; if (bus.if_rvalid !== 1'b1) $display("FAIL same_if_rvalid got %b want 1", bus.if_rvalid); else passed++;
        total++; if (bus.if_rdata !== 32'hDEAD_BEEF) $display("FAIL same_if_rdata got %h want deadbeef", bus.if_rdata); else passed++;
        total++; if (bus.dm_rvalid !== 1'b0) $display("FAIL same_dm_rvalid2 got %b want 0", bus.dm_rvalid); else passed++;
        total++; if (bus.perf_conflicts !== 16'd11) $display("FAIL same_perf got %0d want 11", bus.perf_conflicts); else passed++;
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_dm_read();
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 10'd7;
        @(negedge clk);
        total++; if (bus.dm_gnt !== 1'b1) $display("FAIL dmrd_gnt got %b want 1", bus.dm_gnt); else passed++;
        total++; if (bus.mem_we !== 1'b0) $display("FAIL dmrd_mem_we got %b want 0", bus.mem_we); else passed++;
        total++; if (bus.dm_rvalid !== 1'b0) $display("FAIL dmrd_rvalid0 got %b want 0", bus.dm_rvalid); else passed++;
        next_cycle();
        idle_inputs();
        @(negedge clk);
        total++; if (bus.dm_rvalid !== 1'b1) $display("FAIL dmrd_rvalid1 got %b want 1", bus.dm_rvalid); else passed++;
        total++; if (bus.dm_rdata !== 32'h1234_5678) $display("FAIL dmrd_rdata1 got %h want 12345678", bus.dm_rdata); else passed++;
        total++; if (bus.mem_en !== 1'b0) $display("FAIL dmrd_mem_en got %b want 0", bus.mem_en); else passed++;
        total++; if (bus.mem_addr !== 10'd7) $display("FAIL dmrd_addr_hold got %0d want 7", bus.mem_addr); else passed++;
        next_cycle();
        @(negedge clk);
        total++; if (bus.dm_rvalid !== 1'b0) $display("FAIL dmrd_rvalid2 got %b want 0", bus.dm_rvalid); else passed++;
        total++; if (bus.dm_rdata !== 32'h1234_5678) $display("FAIL dmrd_rdata_hold got %h want 12345678", bus.dm_rdata); else passed++;
        next_cycle();
    endtask

    task automatic test_reset_mid();
        bus.if_req = 1'b1; bus.if_addr = 10'd2;
        @(negedge clk);
        total++; if (bus.if_gnt !== 1'b1) $display("FAIL midrst_gnt got %b want 1", bus.if_gnt); else passed++;
        next_cycle();
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        total++; if (bus.if_rvalid !== 1'b0) $display("FAIL midrst_if_rvalid got %b want 0", bus.if_rvalid); else passed++;
        total++; if (bus.if_rdata !== 32'd0) $display("FAIL midrst_if_rdata got %h want 0", bus.if_rdata); else passed++;
        total++; if (bus.dm_rdata !== 32'd0) $display("FAIL midrst_dm_rdata got %h want 0", bus.dm_rdata); else passed++;
        total++; if (bus.perf_conflicts !== 16'd0) $display("FAIL midrst_perf got %0d want 0", bus.perf_conflicts); else passed++;
        total++; if (bus.mem_addr !== 10'd0) $display("FAIL midrst_mem_addr got %0d want 0", bus.mem_addr); else passed++;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        total++; if (bus.if_rvalid !== 1'b0) $display("FAIL postrst_if_rvalid got %b want 0", bus.if_rvalid); else passed++;
        total++; if (bus.dm_rvalid !== 1'b0) $display("FAIL postrst_dm_rvalid got %b want 0", bus.dm_rvalid); else passed++;
        total++; if (bus.perf_conflicts !== 16'd0) $display("FAIL postrst_perf got %0d want 0", bus.perf_conflicts); else passed++;
        total++; if (bus.dm_rdata !== 32'd0) $display("FAIL postrst_dm_rdata got %h want 0", bus.dm_rdata); else passed++;
        next_cycle();
        test_if_only("postrst");
    endtask

    task automatic test_perf_saturation();
        bus.if_req = 1'b1; bus.if_addr = 10'd0;
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 10'd1;
        repeat (70000) @(posedge clk);
        #1;
        idle_inputs();
        @(negedge clk);
        total++; if (bus.perf_conflicts !== 16'hFFFF) $display("FAIL perf_sat got %h want ffff", bus.perf_conflicts); else passed++;
        next_cycle();
        @(negedge clk);
        total++; if (bus.perf_conflicts !== 16'hFFFF) $display("FAIL perf_hold got %h want ffff", bus.perf_conflicts); else passed++;
        next_cycle();
    endtask

    initial begin
        rst = 1'b1;
        preload = 1'b1;
        idle_inputs();
        next_cycle();
        next_cycle();
        preload = 1'b0;
        test_reset();
        test_if_only("ifonly");
        test_starvation();
        test_same_addr();
        test_dm_read();
        test_reset_mid();
        test_perf_saturation();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
